// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control unit for the multicycle ARM-subset processor. A main FSM steps each
//   instruction through fetch/decode/execute/memory/writeback. A decoder derives
//   ALUControl, ImmSrc and RegSrc. Condition logic keeps the NZCV flags and gates
//   every architectural write with the instruction's condition field.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   Instr      instruction register contents (only [31:12] are used)
//   ALUFlags   {N,Z,C,V} from the datapath ALU in the current cycle
//   PCWrite    PC register enable
//   MemWrite   memory write enable
//   RegWrite   register file write enable
//   IRWrite    instruction register enable
//   AdrSrc     0 = PC, 1 = ALUOut as memory address
//   RegSrc     [0] read R15 as Rn (branch), [1] read Rd as Rm (store)
//   ALUSrcA    00 = register A, 01 = PC
//   ALUSrcB    00 = WriteData, 01 = ExtImm, 10 = constant 4
//   ResultSrc  00 = ALUOut, 01 = Data register, 10 = ALUResult
//   ImmSrc     Instr[27:26]
//   ALUControl 00 add, 01 sub, 10 and, 11 orr
module multicycle_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB,
    MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] flags_reg, flags_next;   // {N,Z,C,V}
  logic       cond_ex_reg, cond_ex_next;

  // Instruction fields
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       s_bit, i_bit, l_bit;

  assign cond  = Instr[31:28];
  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign cmd   = funct[4:1];
  assign s_bit = funct[0];
  assign i_bit = funct[5];
  assign l_bit = funct[0];

  // Low instruction bits belong to the datapath only.
  logic unused_instr_bits;
  assign unused_instr_bits = ^Instr[11:0];

  // Decode-side outputs are purely combinational in every state.
  assign ImmSrc = op;
  assign RegSrc = {(op == 2'b01) & ~l_bit, (op == 2'b10)};

  // Condition check against the stored flags, not the live ALU flags.
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_met;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_reg;

  always_comb begin
    cond_met = 1'b0;
    case (cond)
      4'b0000: cond_met = flag_z;
      4'b0001: cond_met = ~flag_z;
      4'b0010: cond_met = flag_c;
      4'b0011: cond_met = ~flag_c;
      4'b0100: cond_met = flag_n;
      4'b0101: cond_met = ~flag_n;
      4'b0110: cond_met = flag_v;
      4'b0111: cond_met = ~flag_v;
      4'b1000: cond_met = flag_c & ~flag_z;
      4'b1001: cond_met = ~flag_c | flag_z;
      4'b1010: cond_met = (flag_n == flag_v);
      4'b1011: cond_met = (flag_n != flag_v);
      4'b1100: cond_met = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_met = flag_z | (flag_n != flag_v);
      4'b1110: cond_met = 1'b1;
      default: cond_met = 1'b0;   // 1111 never executes
    endcase
  end

  // ALU operation for data-processing commands; unknown commands add.
  logic [1:0] alu_decoded;
  always_comb begin
    alu_decoded = 2'b00;
    case (cmd)
      4'b0100: alu_decoded = 2'b00;
      4'b0010: alu_decoded = 2'b01;
      4'b0000: alu_decoded = 2'b10;
      4'b1100: alu_decoded = 2'b11;
      default: alu_decoded = 2'b00;
    endcase
  end

  // C and V only carry meaning for arithmetic commands.
  logic cmd_arith;
  assign cmd_arith = (cmd == 4'b0100) || (cmd == 4'b0010);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= FETCH;
      flags_reg   <= 4'b0000;
      cond_ex_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      flags_reg   <= flags_next;
      cond_ex_reg <= cond_ex_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    flags_next   = flags_reg;
    cond_ex_next = cond_ex_reg;
    PCWrite      = 1'b0;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    IRWrite      = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ResultSrc    = 2'b00;
    ALUControl   = 2'b00;

    case (state_reg)
      FETCH: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        IRWrite    = 1'b1;
        PCWrite    = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        // PC+8 on ALUResult so R15 reads see the architectural value.
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        cond_ex_next = cond_met;
        case (op)
          2'b00:   state_next = i_bit ? EXECUTEI : EXECUTER;
          2'b01:   state_next = MEMADR;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = 2'b01;
        state_next = l_bit ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = cond_ex_reg;
        state_next = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = cond_ex_reg;
        state_next = FETCH;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcB    = (state_reg == EXECUTEI) ? 2'b01 : 2'b00;
        ALUControl = alu_decoded;
        if (s_bit && cond_ex_reg) begin
          flags_next[3:2] = ALUFlags[3:2];
          if (cmd_arith) flags_next[1:0] = ALUFlags[1:0];
        end
        state_next = ALUWB;
      end
      ALUWB: begin
        RegWrite   = cond_ex_reg;
        PCWrite    = cond_ex_reg & (rd == 4'd15);
        state_next = FETCH;
      end
      BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        PCWrite    = cond_ex_reg;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase

    // Nothing architectural may change while reset is asserted.
    if (reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

endmodule
